// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one 16-bit SPI engine among NUM_REQ requesters, with per-owner CS framing.
// Latency: CS_GAP cycles of CS setup before the first start; word_ack one cycle after engine busy falls.
// Backpressure: requests are level-held; owner must keep tx/div stable until word_ack, others wait.
module spi_xfer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CS_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [16*NUM_REQ-1:0] req_tx,
    input  logic [16*NUM_REQ-1:0] req_div,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    word_ack,
    output logic [15:0]           rx_data,
    output logic [NUM_REQ-1:0]    spi_cs_n,
    output logic                  eng_start,
    output logic [15:0]           eng_tx,
    output logic [15:0]           eng_divisor,
    input  logic                  eng_busy,
    input  logic [15:0]           eng_rx
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CS_SETUP  = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_ACK       = 3'd5;
    localparam logic [2:0] S_CS_HOLD   = 3'd6;

    localparam logic [7:0]         GAP = 8'(CS_GAP);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [2:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [7:0]    gap_cnt;
    logic          last_flag;
    logic [15:0]   owner_tx;
    logic [15:0]   owner_div;
    logic [IW-1:0] rr_next;

    // Scan downwards so the requester closest to rr_ptr is the last writer and wins.
    always_comb begin : pick_scan
        int            idx;
        logic [IW-1:0] idx_s;
        idx      = 0;
        idx_s    = '0;
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_s = IW'(idx);
            if (req[idx_s]) begin
                pick     = idx_s;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        owner_tx  = req_tx[15:0];
        owner_div = req_div[15:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                owner_tx  = req_tx[16*i +: 16];
                owner_div = req_div[16*i +: 16];
            end
        end
    end

    assign rr_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            gap_cnt     <= '0;
            last_flag   <= 1'b0;
            grant       <= '0;
            word_ack    <= '0;
            rx_data     <= '0;
            spi_cs_n    <= '1;
            eng_start   <= 1'b0;
            eng_tx      <= '0;
            eng_divisor <= '0;
        end else begin
            eng_start <= 1'b0;
            word_ack  <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        owner    <= pick;
                        grant    <= ONE << pick;
                        spi_cs_n <= ~(ONE << pick);
                        gap_cnt  <= GAP;
                        state    <= S_CS_SETUP;
                    end
                end
                S_CS_SETUP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        // Word parameters are captured as START is entered, so they are valid with eng_start.
                        eng_start   <= 1'b1;
                        eng_tx      <= owner_tx;
                        eng_divisor <= owner_div;
                        last_flag   <= req_last[owner];
                        state       <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (eng_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!eng_busy) begin
                        rx_data  <= eng_rx;
                        word_ack <= grant;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (last_flag || !req[owner]) begin
                        gap_cnt <= GAP;
                        state   <= S_CS_HOLD;
                    end else begin
                        eng_start   <= 1'b1;
                        eng_tx      <= owner_tx;
                        eng_divisor <= owner_div;
                        last_flag   <= req_last[owner];
                        state       <= S_START;
                    end
                end
                S_CS_HOLD: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        spi_cs_n <= '1;
                        grant    <= '0;
                        rr_ptr   <= rr_next;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one 16-bit SPI master engine among NUM_REQ requesters. Each requester owns a dedicated active-low chip select and supplies its own clock divisor per word. The block issues engine start pulses, tracks engine busy, returns received words, and frames multi-word bursts under one chip select with programmable setup/hold gaps. It sits between the Wishbone-side peripheral cores and the shared SPI engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CS_GAP, 4, clk cycles of chip select setup before first start, and hold after last word (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester transfer request, level
req_last  in  NUM_REQ  current word is the last of the burst
req_tx  in  16*NUM_REQ  tx word, requester i at [16*i+15:16*i]
req_div  in  16*NUM_REQ  sck divisor, same packing
grant  out  NUM_REQ  one-hot owner of the engine, 0 when idle
word_ack  out  NUM_REQ  1-cycle pulse per completed word to the owner
rx_data  out  16  last received word, valid with word_ack
spi_cs_n  out  NUM_REQ  active-low chip selects
eng_start  out  1  start pulse to engine
eng_tx  out  16  tx word to engine
eng_divisor  out  16  divisor to engine
eng_busy  in  1  engine busy
eng_rx  in  16  engine rx register

Behaviour:
- Reset values: grant=0, word_ack=0, rx_data=0, spi_cs_n=all 1, eng_start=0, eng_tx=0, eng_divisor=0, rr pointer=0, state IDLE, gap counter=0.
- States: IDLE, CS_SETUP, START, WAIT_BUSY, WAIT_DONE, ACK, CS_HOLD.
- IDLE: if any req, select first asserted req scanning from rr pointer upward, with wrap-around. Register grant; drive spi_cs_n[owner]=0 the next cycle; load gap counter with CS_GAP; go to CS_SETUP.
- CS_SETUP: decrement counter; at 1, go to START. CS low for exactly CS_GAP cycles before eng_start.
- START: latch eng_tx and eng_divisor from the owner slice and the owner's req_last into last_flag. Assert eng_start for exactly 1 cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for eng_busy=1; the engine raises busy within 2 clk. Go to WAIT_DONE. There is no timeout.
- WAIT_DONE: on eng_busy=0, capture rx_data<=eng_rx and go to ACK.
- ACK: word_ack[owner]=1 for 1 cycle.
  - If last_flag=1 or req[owner]=0, load counter with CS_GAP and go to CS_HOLD.
  - Otherwise go to START for the next word. CS stays low, and the inter-word gap is 1 cycle.
- CS_HOLD: CS stays low for CS_GAP cycles, then goes high. grant<=0, rr pointer<=owner+1 mod NUM_REQ, go to IDLE. At least 1 IDLE cycle with all CS high separates bursts.
- eng_tx and eng_divisor hold their values from START until the next START.
- Requesters must hold req_tx and req_div stable from grant until word_ack. Changes to req_tx/req_div outside START are ignored.
- Dropping req mid-word does not abort the word. The burst ends after that word's ACK.
- Simultaneous requests: the round-robin pointer decides. No requester is granted twice while another is waiting, because the pointer is past the last owner.
- Only grant[owner] and spi_cs_n[owner] are ever active. spi_cs_n is one-cold or all ones.
- Reset mid-burst: all outputs return to reset values immediately (async). The engine is reset by the same rst.

Test Plan:
1. Single word: req[1]=1, req_last[1]=1, tx=16'hA55A, div=2, MISO loopback. Required: grant=4'b0010, cs_n[1] low CS_GAP cycles before eng_start, one eng_start pulse, word_ack[1] with rx_data=16'hA55A, cs_n[1] high CS_GAP cycles after ack.
2. Burst of 3 words: req[0] held, req_last[0] set on the third word, tx=0x0001,0x0002,0x0003. Required: cs_n[0] continuously low, 3 word_ack pulses, rx_data matches each word, one CS_HOLD.
3. Round-robin: req=4'b1111 all single-word. Required: grant order 0,1,2,3, then with req re-asserted 0 again. With rr pointer at 2 and req=4'b0011, the grant goes to 0.
4. Early drop: 5-word burst intended, req[2] deasserted during word 2. Required: word 2 completes with word_ack, no third eng_start, CS_HOLD follows.
5. Per-requester divisor: req0 div=0, req3 div=7. Required: eng_divisor equals the owner's value during each word; the measured sck period scales accordingly.
6. Async reset asserted in WAIT_DONE. Required: cs_n all 1, grant=0, eng_start=0 without waiting for a clk edge. After release, the block is IDLE and a new request completes normally.
